// File: rtl/ldst_unit.sv
// ldst_unit: load/store sequencer between the execute stage and the
// single-port data memory. Stores are buffered in a small store queue (SQ)
// and drained when the memory port is free. Load misses take the port.
// Loads that hit the SQ are forwarded from the youngest matching entry.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake; req_we selects store(1)/load(0)
//   req_addr, req_wdata   request address and store data
//   fence                 pulse: drain the SQ before accepting more requests
//   rsp_valid, rsp_rdata  registered load response, one cycle after accept
//   fence_done            one-cycle pulse when a fence completes
//   MemRead, MemWrite     memory port enables (never both high)
//   mem_addr, mem_wdata   memory port address / write data (zero when idle)
//   mem_rdata             combinational memory read data
//   sq_empty, sq_full     store-queue occupancy flags
module ldst_unit #(
    parameter int SQ_DEPTH = 4,
    parameter int AW       = 8,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic          fence,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          fence_done,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          sq_empty,
    output logic          sq_full
);

    localparam int PW = $clog2(SQ_DEPTH);
    localparam int CW = $clog2(SQ_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(SQ_DEPTH);

    typedef enum logic {
        RUN,
        FENCE
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  sq_addr [SQ_DEPTH];
    logic [DW-1:0]  sq_data [SQ_DEPTH];
    logic [PW-1:0]  head_q, tail_q;
    logic [CW-1:0]  count_q, count_d;

    logic           fwd_hit;
    logic [DW-1:0]  fwd_data;
    logic [PW-1:0]  idx;
    logic           load_acc, store_acc, load_miss, drain;
    logic           fence_done_d;

    // Walk the queue oldest to youngest so the last match (youngest) wins.
    // An entry is live when its age offset from head is below count.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned k = 0; k < SQ_DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (sq_addr[idx] == req_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = sq_data[idx];
            end
        end
    end

    always_comb begin
        sq_empty  = (count_q == '0);
        sq_full   = (count_q == DEPTH_C);
        req_ready = (state_q == RUN) && (!req_we || !sq_full);

        load_acc  = req_valid && req_ready && !req_we;
        store_acc = req_valid && req_ready &&  req_we;
        load_miss = load_acc && !fwd_hit;
        drain     = !load_miss && !sq_empty;

        MemRead   = load_miss;
        MemWrite  = drain;
        mem_addr  = '0;
        mem_wdata = '0;
        if (load_miss) begin
            mem_addr = req_addr;
        end else if (drain) begin
            mem_addr  = sq_addr[head_q];
            mem_wdata = sq_data[head_q];
        end

        count_d = count_q;
        case ({store_acc, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        state_d      = state_q;
        fence_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (fence) begin
                    state_d = FENCE;
                end
            end
            FENCE: begin
                if (count_d == '0) begin
                    state_d      = RUN;
                    fence_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            fence_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            fence_done <= fence_done_d;
            rsp_valid  <= load_acc;
            if (store_acc) begin
                tail_q <= tail_q + 1'b1;
            end
            if (drain) begin
                head_q <= head_q + 1'b1;
            end
            if (load_acc) begin
                rsp_rdata <= fwd_hit ? fwd_data : mem_rdata;
            end
        end
    end

    // Entry storage needs no reset: liveness is governed by count/head.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            sq_addr[tail_q] <= req_addr;
            sq_data[tail_q] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_ldst_unit.sv
module tb_ldst_unit;

    localparam int SQ_DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       fence;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       fence_done;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       sq_empty;
    logic       sq_full;

    ldst_unit #(.SQ_DEPTH(SQ_DEPTH), .AW(8), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .fence(fence),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fence_done(fence_done),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .sq_empty(sq_empty), .sq_full(sq_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Physical data memory: combinational read, write at posedge.
    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h20] = 8'h33;
        forever begin
            @(posedge clk);
            if (MemWrite) mem[mem_addr] <= mem_wdata;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural memory (stores visible immediately in
    // program order), in-order list of stores not yet written to memory,
    // and pending load responses.
    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } st_t;

    logic [7:0] ref_mem [256];
    st_t        wr_q [$];
    logic [7:0] rsp_q [$];
    bit         in_fence = 0;
    bit         fd_exp   = 0;
    bit         resync   = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wr_q.delete();
                rsp_q.delete();
                in_fence = 0;
                fd_exp   = 0;
                resync   = 1;
            end else begin
                int  pend;
                bit  exp_ready, ld, st, miss, drain_exp;
                st_t e;
                if (resync) begin
                    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
                    resync = 0;
                end
                if (rsp_q.size() > 0) begin
                    check("rsp_valid", rsp_valid, 1);
                    check("rsp_rdata", rsp_rdata, rsp_q.pop_front());
                end else begin
                    check("rsp_valid_idle", rsp_valid, 0);
                end
                check("fence_done", fence_done, fd_exp);
                pend = wr_q.size();
                check("sq_empty", sq_empty, pend == 0);
                check("sq_full", sq_full, pend == SQ_DEPTH);
                exp_ready = !in_fence && (!req_we || pend < SQ_DEPTH);
                check("req_ready", req_ready, exp_ready);
                ld = req_valid && exp_ready && !req_we;
                st = req_valid && exp_ready && req_we;
                miss = 0;
                if (ld) begin
                    miss = 1;
                    foreach (wr_q[i]) if (wr_q[i].addr == req_addr) miss = 0;
                    rsp_q.push_back(ref_mem[req_addr]);
                end
                drain_exp = !miss && pend > 0;
                check("MemRead", MemRead, miss);
                check("MemWrite", MemWrite, drain_exp);
                if (miss) begin
                    check("rd_addr", mem_addr, req_addr);
                end else if (drain_exp) begin
                    e = wr_q.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_wdata, e.data);
                end else begin
                    check("idle_addr", mem_addr, 0);
                    check("idle_wdata", mem_wdata, 0);
                end
                if (st) begin
                    ref_mem[req_addr] = req_wdata;
                    wr_q.push_back('{addr: req_addr, data: req_wdata});
                end
                fd_exp = in_fence && wr_q.size() == 0;
                if (!in_fence) in_fence = fence;
                else           in_fence = (wr_q.size() != 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d);
        bit ok;
        ok = 0;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        check("accept_timeout", ok, 1);
        step();
        req_valid = 0; req_we = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; fence = 0; req_valid = 0; req_we = 0;
        repeat (2) step();
        rst_n = 1;
    endtask

    task automatic do_fence_wait();
        bit seen;
        seen = 0;
        fence = 1;
        step();
        fence = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fence_done) begin
                seen = 1;
                break;
            end
        end
        check("fence_timeout", seen, 1);
        step();
    endtask

    initial begin : driver
        rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; fence = 0;
        do_reset();

        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_fence_done", fence_done, 0);
        check("rst_sq_empty", sq_empty, 1);
        check("rst_sq_full", sq_full, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_MemRead", MemRead, 0);
        check("rst_MemWrite", MemWrite, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        step();

        issue(1, 8'h10, 8'h5A);
        @(negedge clk);
        check("st_drain_we", MemWrite, 1);
        check("st_drain_addr", mem_addr, 8'h10);
        check("st_drain_data", mem_wdata, 8'h5A);
        step();

        issue(0, 8'h20, 8'h00);
        @(negedge clk);
        check("ld_rsp_valid", rsp_valid, 1);
        check("ld_rsp_data", rsp_rdata, 8'h33);
        step();

        issue(1, 8'h40, 8'h11);
        issue(0, 8'h50, 8'h00);
        issue(1, 8'h40, 8'h22);
        issue(0, 8'h50, 8'h00);
        issue(0, 8'h40, 8'h00);
        @(negedge clk);
        check("fwd_rsp_data", rsp_rdata, 8'h22);
        step();

        for (int i = 0; i < 4; i++) begin
            issue(1, 8'(8'h60 + i), 8'(8'hA0 + i));
            issue(0, 8'(8'h70 + i), 8'h00);
        end
        repeat (4) step();
        @(negedge clk);
        check("fill_sq_empty", sq_empty, 1);
        step();

        for (int i = 0; i < 3; i++) issue(1, 8'(8'h80 + i), 8'(8'hC0 + i));
        do_fence_wait();
        @(negedge clk);
        check("fence_mem", mem[8'h82], 8'hC2);
        step();

        issue(1, 8'h90, 8'h77);
        do_reset();
        @(negedge clk);
        check("rst2_MemWrite", MemWrite, 0);
        check("rst2_sq_empty", sq_empty, 1);
        check("rst2_rsp_valid", rsp_valid, 0);
        step();

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_we    = 1'($urandom);
                req_addr  = 8'(8'h40 + $urandom_range(0, 3));
                req_wdata = 8'($urandom);
                fence     = ($urandom_range(0, 24) == 0);
                step();
            end
        end
        req_valid = 0; req_we = 0; fence = 0;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
